// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: NUM_OPERANDS x OPERAND_W bits in on PICO, RESULT_W-bit ALU result out on POCI.
// Optional macro SPI_FRAME_ERR_EN adds the frame_error output and its overrun tracking.
module spi_frame_slave #(
    parameter int OPERAND_W    = 32,
    parameter int NUM_OPERANDS = 2,
    parameter int RESULT_W     = 64,
    parameter int SYNC_STAGES  = 2,
    localparam int FRAME_W     = OPERAND_W * NUM_OPERANDS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SPI_CLK,
    input  logic                SPI_PICO,
    input  logic                SPI_CS,
    output logic                SPI_POCI,
    input  logic [RESULT_W-1:0] alu_results,
    output logic [FRAME_W-1:0]  operands,
    output logic                operands_valid,
    output logic                busy,
`ifdef SPI_FRAME_ERR_EN
    output logic                frame_error,
`endif
    output logic [1:0]          fsm_state_o
);

    localparam int CNT_W = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    // Debug encoding on fsm_state_o: 0 = IDLE, 1 = SHIFT, 2 = WAIT_CS_HIGH.
    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_SHIFT        = 2'd1,
        S_WAIT_CS_HIGH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, pico_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [FRAME_W-1:0]     tx_q, tx_d, rx_q, rx_d, ops_q, ops_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   busy_q, busy_d, poci_q, poci_d, valid_q, valid_d;

    // The history flops trail the final synchroniser stage so edges are seen on clean data.
    logic sclk_s, cs_s, pico_s, sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign pico_s    = pico_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    logic [FRAME_W-1:0] tx_load;
    assign tx_load = FRAME_W'(alu_results) << (FRAME_W - RESULT_W);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            pico_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            state_q     <= S_WAIT_CS_HIGH;
            tx_q        <= '0;
            rx_q        <= '0;
            ops_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            poci_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
            pico_sync_q <= {pico_sync_q[SYNC_STAGES-2:0], SPI_PICO};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            state_q     <= state_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            ops_q       <= ops_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            poci_q      <= poci_d;
            valid_q     <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        ops_d   = ops_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        poci_d  = poci_q;
        valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                poci_d = 1'b0;
                if (cs_fall) begin
                    tx_d    = tx_load;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    poci_d  = alu_results[RESULT_W-1];
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // CS rise takes priority; a coincident SCLK edge is dropped.
                if (cs_rise) begin
                    busy_d  = 1'b0;
                    poci_d  = 1'b0;
                    state_d = S_IDLE;
                    if (cnt_q == CNT_FULL) begin
                        ops_d   = rx_q;
                        valid_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    rx_d = {rx_q[FRAME_W-2:0], pico_s};
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
                end else if (sclk_fall) begin
                    tx_d   = tx_q << 1;
                    poci_d = tx_q[FRAME_W-2];
                end
            end
            S_WAIT_CS_HIGH: begin
                poci_d = 1'b0;
                busy_d = 1'b0;
                if (cs_s && cs_prev_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SPI_FRAME_ERR_EN
    logic overrun_q, err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= (state_q == S_SHIFT) && cs_rise && ((cnt_q != CNT_FULL) || overrun_q);
            if (state_q == S_IDLE && cs_fall)
                overrun_q <= 1'b0;
            else if (state_q == S_SHIFT && cnt_q == CNT_MAX)
                overrun_q <= 1'b1;
        end
    end
    assign frame_error = err_q;
`endif

    assign SPI_POCI       = poci_q;
    assign operands       = ops_q;
    assign operands_valid = valid_q;
    assign busy           = busy_q;
    assign fsm_state_o    = state_q;

endmodule
